// File: rtl/ula_audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : ula_audio_mixer
// Purpose  : Mixes beeper/MIC/EAR into a low-passed, sigma-delta 4-bit DAC code.
// Revision : 1.0
// ============================================================================
module ula_audio_mixer #(
    parameter int TICK_DIV = 8,
    parameter int SHIFT    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beeper,
    input  logic       mic,
    input  logic       ear,
    input  logic [1:0] vol,
    output logic [3:0] audio_l,
    output logic [3:0] audio_r,
    output logic       sample_strobe
);

    localparam int              TCW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TCW-1:0]  C_TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [15:0]     C_BEEP_W    = 16'hC000;
    localparam logic [15:0]     C_EAR_W     = 16'h3000;
    localparam logic [15:0]     C_MIC_W     = 16'h0800;

    logic           ear_meta_q;
    logic           ear_s_q;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           tick_d_q;
    logic [15:0]    target_q, target_d;
    logic [15:0]    acc_q, acc_d;
    logic [11:0]    err_q;
    logic [3:0]     code_q;
    logic           strobe_q;

    logic           w_tick;
    logic [15:0]    w_base;
    logic signed [16:0] w_diff;
    logic [12:0]    w_sum;
    logic [4:0]     w_code_wide;
    logic [3:0]     w_code_sat;

    always_comb begin
        w_tick = (tcnt_q == C_TICK_LAST);
        tcnt_d = w_tick ? '0 : tcnt_q + TCW'(1);

        w_base = (beeper  ? C_BEEP_W : 16'h0000)
               + (ear_s_q ? C_EAR_W  : 16'h0000)
               + (mic     ? C_MIC_W  : 16'h0000);
        case (vol)
            2'd0:    target_d = 16'h0000;
            2'd1:    target_d = w_base >> 2;
            2'd2:    target_d = w_base >> 1;
            default: target_d = w_base;
        endcase

        // The arithmetic shift rounds toward -inf, so a rising step stops short
        // of the target and a falling step never passes it: acc cannot wrap.
        w_diff = $signed({1'b0, target_q}) - $signed({1'b0, acc_q});
        acc_d  = w_tick ? acc_q + 16'(w_diff >>> SHIFT) : acc_q;

        w_sum       = {1'b0, err_q} + {1'b0, acc_q[11:0]};
        w_code_wide = {1'b0, acc_q[15:12]} + {4'b0000, w_sum[12]};
        w_code_sat  = w_code_wide[4] ? 4'hF : w_code_wide[3:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ear_meta_q <= 1'b0;
            ear_s_q    <= 1'b0;
            tcnt_q     <= '0;
            tick_d_q   <= 1'b0;
            target_q   <= 16'h0000;
            acc_q      <= 16'h0000;
            err_q      <= 12'h000;
            code_q     <= 4'h0;
            strobe_q   <= 1'b0;
        end else begin
            ear_meta_q <= ear;
            ear_s_q    <= ear_meta_q;
            tcnt_q     <= tcnt_d;
            tick_d_q   <= w_tick;
            target_q   <= target_d;
            acc_q      <= acc_d;
            strobe_q   <= tick_d_q;
            // Error feedback keeps running even when the code saturates.
            if (tick_d_q) begin
                err_q  <= w_sum[11:0];
                code_q <= w_code_sat;
            end
        end
    end

    assign audio_l       = code_q;
    assign audio_r       = code_q;
    assign sample_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_audio_mixer
// Purpose  : Directed self-checking bench for ula_audio_mixer.
// Revision : 1.0
// ============================================================================
module tb_ula_audio_mixer;

    localparam int TICK_DIV = 8;
    localparam int SHIFT    = 4;
    localparam int SETTLE   = 300 * TICK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       beeper = 1'b0;
    logic       mic = 1'b0;
    logic       ear = 1'b0;
    logic [1:0] vol = 2'd0;
    logic [3:0] audio_l;
    logic [3:0] audio_r;
    logic       sample_strobe;

    int checks = 0;
    int errors = 0;
    int exp_acc  [8];
    int exp_code [8];

    ula_audio_mixer #(.TICK_DIV(TICK_DIV), .SHIFT(SHIFT)) dut (
        .clk           (clk),
        .reset         (reset),
        .beeper        (beeper),
        .mic           (mic),
        .ear           (ear),
        .vol           (vol),
        .audio_l       (audio_l),
        .audio_r       (audio_r),
        .sample_strobe (sample_strobe)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(output int clocks);
        step_clk();
        clocks = 1;
        while (!sample_strobe && clocks < 4 * TICK_DIV) begin
            step_clk();
            clocks++;
        end
        if (!sample_strobe) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: no sample_strobe within %0d clocks", clocks);
        end
    endtask

    // Reference: filter then first-order sigma-delta, for a constant target.
    task automatic compute_model(input int target);
        int acc, err, sum, code;
        acc = 0;
        err = 0;
        for (int i = 0; i < 8; i++) begin
            acc  = acc + ((target - acc) >>> SHIFT);
            sum  = err + (acc & 4095);
            err  = sum & 4095;
            code = (acc >> 12) + (sum >> 12);
            if (code > 15) code = 15;
            exp_acc[i]  = acc;
            exp_code[i] = code;
        end
    endtask

    task automatic apply_reset(input logic b, input logic m, input logic e, input logic [1:0] v);
        reset  = 1'b1;
        beeper = b;
        mic    = m;
        ear    = e;
        vol    = v;
        repeat (2) step_clk();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset  = 1'b1;
        beeper = 1'b1;
        mic    = 1'b1;
        ear    = 1'b1;
        vol    = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            checks++;
            if ({audio_l, audio_r, sample_strobe} !== 9'd0) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d got l=%0d r=%0d strobe=%0b expected 0 0 0",
                         i, audio_l, audio_r, sample_strobe);
            end
        end
        checks++;
        if (dut.acc_q !== 16'd0 || dut.target_q !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got acc=%0d target=%0d expected 0 0", dut.acc_q, dut.target_q);
        end
        reset = 1'b0;
        wait_strobe(n);
        checks++;
        if (n !== TICK_DIV + 1) begin
            errors++;
            $display("FAIL first_strobe: got clock %0d expected %0d", n, TICK_DIV + 1);
        end
    endtask

    task automatic test_beeper_step();
        int n, total;
        apply_reset(1'b0, 1'b0, 1'b0, 2'd3);
        beeper = 1'b1;
        step_clk();
        checks++;
        if (dut.target_q !== 16'hC000) begin
            errors++;
            $display("FAIL beeper_target_latency: got %h expected c000", dut.target_q);
        end
        compute_model(49152);
        for (int i = 0; i < 8; i++) begin
            wait_strobe(n);
            if (i == 0) begin
                checks++;
                if (dut.acc_q !== 16'd3072) begin
                    errors++;
                    $display("FAIL step_acc_tick1: got %0d expected 3072", dut.acc_q);
                end
            end
            if (i == 1) begin
                checks++;
                if (dut.acc_q !== 16'd5952) begin
                    errors++;
                    $display("FAIL step_acc_tick2: got %0d expected 5952", dut.acc_q);
                end
            end
            checks++;
            if (audio_l !== 4'(exp_code[i]) || audio_r !== 4'(exp_code[i]) || dut.acc_q !== 16'(exp_acc[i])) begin
                errors++;
                $display("FAIL step_seq[%0d]: got l=%0d r=%0d acc=%0d expected code=%0d acc=%0d",
                         i, audio_l, audio_r, dut.acc_q, exp_code[i], exp_acc[i]);
            end
        end
        repeat (SETTLE) step_clk();
        total = 0;
        for (int i = 0; i < 32; i++) begin
            wait_strobe(n);
            total += int'(audio_l);
            checks++;
            if ((audio_l !== 4'd11 && audio_l !== 4'd12) || audio_r !== audio_l) begin
                errors++;
                $display("FAIL step_settled: got l=%0d r=%0d expected 11 or 12", audio_l, audio_r);
            end
        end
        checks++;
        if (total * 10 < 119 * 32) begin
            errors++;
            $display("FAIL step_mean: got sum %0d over 32 expected at least %0d", total * 10, 119 * 32);
        end
    endtask

    task automatic test_strobe_period();
        int n;
        for (int i = 0; i < 5; i++) begin
            wait_strobe(n);
            checks++;
            if (n !== TICK_DIV) begin
                errors++;
                $display("FAIL strobe_period: got %0d clocks expected %0d", n, TICK_DIV);
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        beeper = 1'b1;
        mic    = 1'b1;
        ear    = 1'b1;
        vol    = 2'd3;
        repeat (SETTLE) step_clk();
        for (int i = 0; i < 32; i++) begin
            wait_strobe(n);
            checks++;
            if (audio_l !== 4'd15 || audio_r !== 4'd15) begin
                errors++;
                $display("FAIL saturation: got l=%0d r=%0d expected 15", audio_l, audio_r);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        reset  = 1'b1;
        beeper = 1'b1;
        mic    = 1'b0;
        ear    = 1'b0;
        step_clk();
        checks++;
        if (audio_l !== 4'd0 || audio_r !== 4'd0 || sample_strobe !== 1'b0 || dut.acc_q !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got l=%0d r=%0d strobe=%0b acc=%0d expected 0 0 0 0",
                     audio_l, audio_r, sample_strobe, dut.acc_q);
        end
        step_clk();
        reset = 1'b0;
        compute_model(49152);
        for (int i = 0; i < 8; i++) begin
            wait_strobe(n);
            if (i == 0) begin
                checks++;
                if (n !== TICK_DIV + 1) begin
                    errors++;
                    $display("FAIL mid_reset_first_strobe: got clock %0d expected %0d", n, TICK_DIV + 1);
                end
            end
            checks++;
            if (audio_l !== 4'(exp_code[i]) || dut.acc_q !== 16'(exp_acc[i])) begin
                errors++;
                $display("FAIL mid_reset_seq[%0d]: got code=%0d acc=%0d expected code=%0d acc=%0d",
                         i, audio_l, dut.acc_q, exp_code[i], exp_acc[i]);
            end
        end
    endtask

    task automatic test_volume();
        int n;
        apply_reset(1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 16; i++) begin
            wait_strobe(n);
            checks++;
            if (audio_l !== 4'd0 || audio_r !== 4'd0) begin
                errors++;
                $display("FAIL vol_mute: got l=%0d r=%0d expected 0", audio_l, audio_r);
            end
        end
        apply_reset(1'b1, 1'b0, 1'b0, 2'd2);
        repeat (SETTLE) step_clk();
        for (int i = 0; i < 16; i++) begin
            wait_strobe(n);
            checks++;
            if ((audio_l !== 4'd5 && audio_l !== 4'd6) || audio_r !== audio_l) begin
                errors++;
                $display("FAIL vol_half: got l=%0d r=%0d expected 5 or 6", audio_l, audio_r);
            end
        end
    endtask

    task automatic test_ear_sync();
        int n;
        apply_reset(1'b0, 1'b0, 1'b0, 2'd3);
        repeat (3) step_clk();
        ear = 1'b1;
        step_clk();
        step_clk();
        checks++;
        if (dut.target_q !== 16'h0000) begin
            errors++;
            $display("FAIL ear_sync_early: got %h expected 0000 after 2 clocks", dut.target_q);
        end
        step_clk();
        checks++;
        if (dut.target_q !== 16'h3000) begin
            errors++;
            $display("FAIL ear_sync_latency: got %h expected 3000 after 3 clocks", dut.target_q);
        end
        repeat (SETTLE) step_clk();
        for (int i = 0; i < 16; i++) begin
            wait_strobe(n);
            checks++;
            if ((audio_l !== 4'd2 && audio_l !== 4'd3) || audio_r !== audio_l) begin
                errors++;
                $display("FAIL ear_settled: got l=%0d r=%0d expected 2 or 3", audio_l, audio_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beeper_step();
        test_strobe_period();
        test_saturation();
        test_mid_reset();
        test_volume();
        test_ear_sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
